// File: rtl/consumer_fsm_pkg.sv
// Shared types and defaults for the dual-lane consumer: merge state,
// parameter defaults and the FIFO pointer-width helper.
package consumer_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int SKID_DEF       = 2;
  localparam int ERR_W_DEF      = 16;

  typedef enum logic {
    EXPECT_L1 = 1'b0,
    EXPECT_L2 = 1'b1
  } merge_state_t;

  // Width of a pointer addressing 'depth' entries (at least one bit).
  function automatic int ptr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/consumer_fsm_if.sv
// Producer-facing lane inputs with stall feedback, plus the merged
// valid/ready output stream of the consumer.
interface consumer_fsm_if #(
  parameter int DATA_W = consumer_pkg::DATA_W_DEF
);
  logic [1:0]        in_valid;
  logic [DATA_W-1:0] pipeline1_outputs;
  logic [DATA_W-1:0] pipeline2_outputs;
  logic              stall_1;
  logic              stall_2;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, pipeline1_outputs, pipeline2_outputs, out_ready,
    input  stall_1, stall_2, out_valid, out_data
  );

  modport slave (
    input  in_valid, pipeline1_outputs, pipeline2_outputs, out_ready,
    output stall_1, stall_2, out_valid, out_data
  );
endinterface

// File: rtl/consumer_fsm_lane_fifo.sv
// Per-lane synchronous FIFO with occupancy count; push into a full FIFO is
// only accepted when a pop frees the head slot in the same cycle.
module lane_fifo
  import consumer_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = FIFO_DEPTH_DEF,
  localparam int PTR_W  = ptr_width(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    count_next = count_reg;
    unique case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr_reg] <= push_data;
  end

  // Head is read combinationally so the merge sees a word the cycle after it lands.
  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/consumer_fsm.sv
// Dual-lane sink: buffers each lane, merges them in even/odd order onto a
// valid/ready stream, and checks the merged sequence against a running count.
module consumer_fsm
  import consumer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int SKID       = SKID_DEF,
  parameter int ERR_W      = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  consumer_fsm_if.slave    bus,
  output logic [ERR_W-1:0] err_count,
  output logic             mismatch,
  output logic             overflow
);

  localparam int CNT_W    = ptr_width(FIFO_DEPTH) + 1;
  localparam int STALL_AT = FIFO_DEPTH - SKID;

  merge_state_t      state_reg;
  logic [DATA_W-1:0] exp_reg;
  logic [ERR_W-1:0]  err_count_reg;
  logic              mismatch_reg;
  logic              overflow_reg;

  logic [DATA_W-1:0] lane_data  [2];
  logic [DATA_W-1:0] lane_head  [2];
  logic [CNT_W-1:0]  lane_count [2];
  logic [1:0]        lane_full;
  logic [1:0]        lane_empty;
  logic [1:0]        lane_push;
  logic [1:0]        lane_pop;
  logic [1:0]        lane_drop;
  logic [1:0]        lane_stall;

  logic              sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              xfer;

  assign lane_data[0] = bus.pipeline1_outputs;
  assign lane_data[1] = bus.pipeline2_outputs;

  assign sel       = (state_reg == EXPECT_L2);
  assign out_valid = ~lane_empty[sel];
  assign out_data  = out_valid ? lane_head[sel] : '0;
  assign xfer      = out_valid & bus.out_ready & ~clear;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_pop[gi]   = xfer & (sel == (gi == 1));
    assign lane_push[gi]  = bus.in_valid[gi] & ~clear;
    assign lane_drop[gi]  = bus.in_valid[gi] & lane_full[gi] & ~lane_pop[gi] & ~clear;
    assign lane_stall[gi] = (lane_count[gi] >= CNT_W'(STALL_AT));

    lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .push      (lane_push[gi]),
      .pop       (lane_pop[gi]),
      .push_data (lane_data[gi]),
      .head_data (lane_head[gi]),
      .count     (lane_count[gi]),
      .full      (lane_full[gi]),
      .empty     (lane_empty[gi])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= EXPECT_L1;
      exp_reg       <= '0;
      err_count_reg <= '0;
      mismatch_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (|lane_drop) overflow_reg <= 1'b1;
      if (clear) begin
        state_reg <= EXPECT_L1;
        exp_reg   <= '0;
      end else if (xfer) begin
        state_reg <= (state_reg == EXPECT_L1) ? EXPECT_L2 : EXPECT_L1;
        exp_reg   <= exp_reg + DATA_W'(1);
        if (out_data != exp_reg) begin
          mismatch_reg <= 1'b1;
          if (err_count_reg != '1) err_count_reg <= err_count_reg + ERR_W'(1);
        end
      end
    end
  end

  assign bus.stall_1   = lane_stall[0];
  assign bus.stall_2   = lane_stall[1];
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign err_count     = err_count_reg;
  assign mismatch      = mismatch_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_consumer_fsm.sv
// Scoreboard bench for consumer_fsm: a queue-level model predicts each
// merged word and the status flags; a negedge monitor checks every handshake.
module tb_consumer_fsm;
  import consumer_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SKID  = 2;
  localparam int EW    = 4;
  localparam int EMAX  = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [EW-1:0] err_count;
  logic          mismatch;
  logic          overflow;

  consumer_fsm_if #(.DATA_W(DW)) bus ();

  consumer_fsm #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .SKID(SKID), .ERR_W(EW)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus),
    .err_count(err_count), .mismatch(mismatch), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: lane contents as queues, output order by turn parity.
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  logic [DW-1:0] sb[$];
  int            lane_m;
  logic [DW-1:0] exp_m;
  int            err_m;
  bit            mis_m;
  bit            ovf_m;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    q1.delete(); q2.delete(); sb.delete();
    lane_m = 0; exp_m = '0; err_m = 0; mis_m = 0; ovf_m = 0;
  endtask

  task automatic check_outputs();
    int            sz;
    logic [DW-1:0] hd;
    sz = (lane_m == 0) ? q1.size() : q2.size();
    hd = '0;
    if (sz > 0) hd = (lane_m == 0) ? q1[0] : q2[0];
    check("out_valid", 64'(bus.out_valid), 64'(sz > 0));
    check("out_data", 64'(bus.out_data), 64'(hd));
    check("stall_1", 64'(bus.stall_1), 64'(q1.size() >= DEPTH - SKID));
    check("stall_2", 64'(bus.stall_2), 64'(q2.size() >= DEPTH - SKID));
    check("err_count", 64'(err_count), 64'(err_m));
    check("mismatch", 64'(mismatch), 64'(mis_m));
    check("overflow", 64'(overflow), 64'(ovf_m));
  endtask

  // One cycle: check current outputs, drive inputs, advance the model.
  task automatic step(input logic [1:0] v, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                      input logic rdy, input logic clr);
    logic [DW-1:0] val;
    bit            fired;
    check_outputs();
    bus.in_valid          = v;
    bus.pipeline1_outputs = d1;
    bus.pipeline2_outputs = d2;
    bus.out_ready         = rdy;
    clear                 = clr;
    fired = 0;
    val   = '0;
    if (clr) begin
      q1.delete(); q2.delete();
      exp_m = '0; lane_m = 0;
    end else begin
      if (rdy && lane_m == 0 && q1.size() > 0) begin val = q1.pop_front(); fired = 1; end
      else if (rdy && lane_m == 1 && q2.size() > 0) begin val = q2.pop_front(); fired = 1; end
      if (fired) begin
        sb.push_back(val);
        if (val != exp_m) begin
          mis_m = 1;
          if (err_m < EMAX) err_m++;
        end
        exp_m  = exp_m + 1;
        lane_m = 1 - lane_m;
      end
      if (v[0]) begin if (q1.size() < DEPTH) q1.push_back(d1); else ovf_m = 1; end
      if (v[1]) begin if (q2.size() < DEPTH) q2.push_back(d2); else ovf_m = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(2'b00, '0, '0, rdy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready && !clear) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL handshake: got data %0d expected no transfer", bus.out_data);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        $display("xfer data=%0d expected=%0d err_count=%0d", bus.out_data, e, err_count);
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL xfer_data: got %0d expected %0d", bus.out_data, e);
        end
      end
    end
  end

  initial begin
    logic [1:0]    v;
    logic [DW-1:0] d1, d2, n1, n2;
    logic          rdy, clr;

    reset = 1'b1; clear = 1'b0;
    bus.in_valid = '0; bus.pipeline1_outputs = '0; bus.pipeline2_outputs = '0; bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;

    // Basic order
    step(2'b11, 0, 1, 1, 0); step(2'b11, 2, 3, 1, 0); step(2'b11, 4, 5, 1, 0);
    idle(7, 1);

    // Backpressure
    step(2'b00, 0, 0, 1, 1);
    step(2'b01, 0, 0, 0, 0); step(2'b01, 2, 0, 0, 0);
    idle(2, 0);
    step(2'b10, 0, 1, 1, 0); step(2'b10, 0, 3, 1, 0);
    idle(4, 1);

    // Overflow: fifth lane-1 word is dropped
    step(2'b00, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(2'b01, DW'(2 * i), 0, 0, 0);
    idle(1, 0);
    for (int i = 0; i < 4; i++) step(2'b10, 0, DW'(2 * i + 1), 1, 0);
    idle(8, 1);

    // Mismatch on lane 2
    step(2'b00, 0, 0, 1, 1);
    step(2'b11, 0, 7, 1, 0); step(2'b11, 2, 3, 1, 0);
    idle(5, 1);

    // Lane skew
    step(2'b00, 0, 0, 1, 1);
    step(2'b10, 0, 1, 1, 0); step(2'b10, 0, 3, 1, 0);
    idle(2, 1);
    step(2'b01, 0, 0, 1, 0); step(2'b01, 2, 0, 1, 0);
    idle(5, 1);

    // Clear with three words buffered, then resume from 0
    step(2'b00, 0, 0, 1, 1);
    step(2'b01, 0, 0, 0, 0); step(2'b10, 0, 1, 0, 0); step(2'b01, 2, 0, 0, 0);
    step(2'b00, 0, 0, 0, 1);
    idle(1, 1);
    step(2'b11, 0, 1, 1, 0); step(2'b11, 2, 3, 1, 0);

    // Asynchronous reset mid-stream
    reset = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_stall_1", 64'(bus.stall_1), 64'(0));
    check("rst_stall_2", 64'(bus.stall_2), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    check("rst_mismatch", 64'(mismatch), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs();

    // Randomized traffic with occasional corruption and clears
    n1 = 0; n2 = 1;
    for (int c = 0; c < 1500; c++) begin
      clr = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      v[0] = ($urandom_range(0, 9) < 4);
      v[1] = ($urandom_range(0, 9) < 4);
      d1 = n1; d2 = n2;
      if ($urandom_range(0, 49) == 0) d1 = d1 ^ 32'h100;
      if ($urandom_range(0, 49) == 0) d2 = d2 ^ 32'h40;
      if (clr) begin
        n1 = 0; n2 = 1;
      end else begin
        if (v[0]) n1 = n1 + 2;
        if (v[1]) n2 = n2 + 2;
      end
      step(v, d1, d2, rdy, clr);
    end
    idle(12, 1);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
